// File: rtl/instr_sequencer.sv
// instr_sequencer: buffers {func,rx,ry,data} instructions in a small FIFO and issues them one at a
// time to the control unit as a single-cycle w pulse. Optional WAIT timeout: define SEQ_TIMEOUT_EN.
module instr_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
`ifdef SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_func,
  input  logic [3:0]    in_rx,
  input  logic [3:0]    in_ry,
  input  logic [3:0]    in_data,
  output logic          w,
  output logic [2:0]    func,
  output logic [3:0]    rx,
  output logic [3:0]    ry,
  output logic [3:0]    data,
  input  logic          done,
  output logic          busy,
  output logic [AW:0]   fifo_count,
  output logic [7:0]    issued_count,
  output logic [1:0]    seq_state,
  output logic          error
);

  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [2:0] func;
    logic [3:0] rx;
    logic [3:0] ry;
    logic [3:0] data;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  instr_t        mem [DEPTH];
  instr_t        in_word;
  instr_t        instr_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic [7:0]    issued_q;
  logic          push, pop;
  logic          fifo_nonempty;
  logic          timeout_hit;

  assign in_word       = {in_func, in_rx, in_ry, in_data};
  assign fifo_nonempty = (count_q != '0);
  assign in_ready      = rst & (count_q < CW'(DEPTH));
  assign push          = in_valid & in_ready;

  // FIFO storage and pointers; the head is only read from the registered count, so no fall-through.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and pop; done wins over a timeout in the same WAIT cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done) begin
          if (fifo_nonempty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issued instruction fields and issue counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q  <= '0;
      issued_q <= '0;
    end else begin
      if (pop)              instr_q  <= mem[rd_ptr];
      if (state_q == ISSUE) issued_q <= issued_q + 8'd1;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  assign timeout_hit = (state_q == WAIT) && (wait_cnt == TW'(TIMEOUT - 1));

  // Counts WAIT cycles without done; error is sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ISSUE)                 wait_cnt <= '0;
      else if ((state_q == WAIT) && !done)  wait_cnt <= wait_cnt + TW'(1);
      if (timeout_hit && !done)             err_q    <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  assign w            = (state_q == ISSUE);
  assign busy         = (state_q != IDLE) | fifo_nonempty;
  assign fifo_count   = count_q;
  assign issued_count = issued_q;
  assign seq_state    = state_q;
  assign func         = instr_q.func;
  assign rx           = instr_q.rx;
  assign ry           = instr_q.ry;
  assign data         = instr_q.data;

endmodule
